// File: rtl/rda_pkg.sv
// Shared types and carry-code helpers for the recursive doubling adder front-end.
package rda_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] CIN_KILL = 2'b00;
    localparam logic [1:0] CIN_GEN  = 2'b11;

    function automatic logic legal_cin(input logic [1:0] code);
        return (code == CIN_KILL) || (code == CIN_GEN);
    endfunction

endpackage

// File: rtl/rda_operand_loader_adder.sv
// Combinational recursive doubling (parallel-prefix) adder; the carry code acts as
// the kill/generate status of a virtual bit below bit 0.
module Recursive_Doubling_Adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   Cin,
    output logic [N:0]   Sum,
    output logic         Cout
);
    localparam int LV = $clog2(N + 1);

    // Index i holds the status of the span ending at bit i-1; index 0 is the carry-in.
    logic [LV:0][N:0] w_g;
    logic [LV:0][N:0] w_p;

    assign w_g[0] = {A & B, Cin[1] & Cin[0]};
    assign w_p[0] = {A ^ B, 1'b0};

    genvar lv, gi;
    generate
        for (lv = 1; lv <= LV; lv++) begin : g_level
            for (gi = 0; gi <= N; gi++) begin : g_bit
                if (gi >= (2 ** (lv - 1))) begin : g_comb
                    assign w_g[lv][gi] = w_g[lv-1][gi]
                                       | (w_p[lv-1][gi] & w_g[lv-1][gi - (2 ** (lv - 1))]);
                    assign w_p[lv][gi] = w_p[lv-1][gi] & w_p[lv-1][gi - (2 ** (lv - 1))];
                end else begin : g_pass
                    assign w_g[lv][gi] = w_g[lv-1][gi];
                    assign w_p[lv][gi] = w_p[lv-1][gi];
                end
            end
        end
    endgenerate

    assign Sum  = {w_g[LV][N], A ^ B ^ w_g[LV][N-1:0]};
    assign Cout = w_g[LV][N];

endmodule

// File: rtl/rda_operand_loader.sv
// Beat-serial operand loader around the recursive doubling adder: assembles A and B,
// runs one add, and holds the registered result on a valid/ready output.
module rda_operand_loader
    import rda_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_sum,
    output logic         out_cout,
    output logic         out_err
);
    localparam int NW = N / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [1:0]    r_cin;
    logic          r_err;
    logic [N:0]    r_sum;
    logic          r_cout;
    logic          r_out_valid;

    logic [N:0]    w_sum;
    logic          w_cout;

    Recursive_Doubling_Adder #(.N(N)) u_adder (
        .A    (r_a),
        .B    (r_b),
        .Cin  (r_cin),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // Held low through reset so no beat is taken before the loader is live.
    assign in_ready  = rst_n && ((r_state == LOAD_A) || (r_state == LOAD_B));
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= CIN_KILL;
            r_err       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: if (in_valid) begin
                    r_a[r_cnt*W +: W] <= in_data;
                    if (r_cnt == '0) begin
                        r_cin <= legal_cin(in_cin) ? in_cin : CIN_KILL;
                        r_err <= !legal_cin(in_cin);
                    end
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= LOAD_B;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOAD_B: if (in_valid) begin
                    r_b[r_cnt*W +: W] <= in_data;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    r_sum       <= w_sum;
                    r_cout      <= w_cout;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_err       <= 1'b0;
                    r_state     <= LOAD_A;
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

endmodule
